// File: rtl/emitter_uart.sv
// Transmit-only 8N1 UART serializer. Each bit lasts DIV = clk_freq_hz / baud_rate clocks.
// Define EMITTER_UART_FIFO_EN to put a FIFO_DEPTH-entry byte FIFO in front of the serializer.
module emitter_uart #(
   parameter int unsigned clk_freq_hz = 50000000,
   parameter int unsigned baud_rate   = 115200,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_uart_tx
);

   localparam int unsigned DIV = clk_freq_hz / baud_rate;
   localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("emitter_uart: clk_freq_hz / baud_rate must be at least 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("emitter_uart: FIFO_DEPTH must be a power of two in 2..16");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [7:0]    shift;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic          idle_r;
   logic          start_req;
   logic [7:0]    start_data;
   logic          bit_end;

   assign bit_end = (cnt == CNT_MAX);

`ifdef EMITTER_UART_FIFO_EN
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   // A full FIFO refuses the push even when the serializer pops on the same edge.
   assign o_ready    = (count != FULL_CNT);
   assign push       = i_valid & o_ready;
   assign pop        = idle_r & (count != '0);
   assign start_req  = pop;
   assign start_data = mem[rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_data;
   end
`else
   assign o_ready    = idle_r;
   assign start_req  = i_valid & idle_r;
   assign start_data = i_data;
`endif

   // shift[0] always holds the next data bit; the frame owns its copy once started.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         shift     <= '0;
         cnt       <= '0;
         bit_idx   <= '0;
         idle_r    <= 1'b1;
         o_uart_tx <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start_req) begin
                  shift     <= start_data;
                  o_uart_tx <= 1'b0;
                  idle_r    <= 1'b0;
                  cnt       <= '0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt       <= '0;
                  o_uart_tx <= shift[0];
                  shift     <= shift >> 1;
                  bit_idx   <= '0;
                  state     <= DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     o_uart_tx <= 1'b1;
                     state     <= STOP;
                  end else begin
                     o_uart_tx <= shift[0];
                     shift     <= shift >> 1;
                     bit_idx   <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt    <= '0;
                  idle_r <= 1'b1;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_emitter_uart.sv
// Bench for emitter_uart: drivers push expected bytes, a line monitor decodes frames and
// compares every sample of each frame against the ideal 8N1 waveform of the expected byte.
module tb_emitter_uart;

   localparam int CLK_HZ = 45000000;
   localparam int BAUD   = 1000000;
   localparam int DIV    = CLK_HZ / BAUD;
   localparam int DEPTH  = 4;
   localparam int FRAME  = 10 * DIV;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;

   int checks      = 0;
   int failures    = 0;
   int frames_seen = 0;
   int last_gap    = -1;
   int idle_cnt    = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];

   emitter_uart #(
      .clk_freq_hz(CLK_HZ),
      .baud_rate  (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_data   (data),
      .i_valid  (valid),
      .o_ready  (ready),
      .o_uart_tx(tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Line monitor: a frame begins at the first low sample; each sample is compared with
   // the ideal waveform {start 0, data LSB first, stop 1}, and bit centres are decoded.
   initial begin : monitor
      logic [7:0] exp_b;
      logic [7:0] rx_b;
      logic       exp_bit;
      int         wave_err;
      int         bit_no;
      bit         aborted;
      bit         have_exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            idle_cnt = 0;
            continue;
         end
         if (tx !== 1'b0) begin
            idle_cnt++;
            continue;
         end
         last_gap = idle_cnt;
         idle_cnt = 0;
         frames_seen++;
         have_exp = (exp_q.size() > 0);
         exp_b    = have_exp ? exp_q.pop_front() : 8'h00;
         rx_b     = 8'h00;
         wave_err = 0;
         aborted  = 1'b0;
         for (int t = 0; t < FRAME; t++) begin
            if (t > 0) @(negedge clk);
            if (!rst_n) begin
               aborted = 1'b1;
               break;
            end
            bit_no  = t / DIV;
            exp_bit = (bit_no == 0) ? 1'b0 : (bit_no == 9) ? 1'b1 : exp_b[bit_no-1];
            if (tx !== exp_bit) wave_err++;
            if ((t % DIV) == (DIV / 2) && bit_no >= 1 && bit_no <= 8) rx_b[bit_no-1] = tx;
         end
         idle_cnt = 0;
         if (!aborted) begin
            check("frame_expected", int'(have_exp), 1);
            if (have_exp) begin
               check("frame_byte", int'(rx_b), int'(exp_b));
               check("frame_wave_errors", wave_err, 0);
            end
            rx_log.push_back(rx_b);
         end
      end
   end

   task automatic wait_ready(input string name, input int bound);
      int n = 0;
      while (ready !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(n < bound), 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit check_busy);
      int busy = 0;
      wait_ready("ready_before_send", 4 * FRAME);
      data  = b;
      valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
      valid = 1'b0;
      data  = 8'($urandom_range(0, 255));
      if (check_busy) begin
         while (ready === 1'b0 && busy < 2 * FRAME) begin
            busy++;
            @(negedge clk);
         end
         check("busy_cycles", busy, FRAME);
      end
   endtask

   task automatic wait_frames_done(input string name, input int bound);
      int n = 0;
      while (!(exp_q.size() == 0 && ready === 1'b1 && idle_cnt >= 3) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(n < bound), 1);
   endtask

   initial begin : stimulus
      int v_tx;
      int v_rdy;
      int f0;
      int lows;
      logic [7:0] fb [5];

      // Reset: line high and ready throughout reset and after release.
      v_tx  = 0;
      v_rdy = 0;
      repeat (5) begin
         @(negedge clk);
         if (tx !== 1'b1) v_tx++;
         if (ready !== 1'b1) v_rdy++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (tx !== 1'b1) v_tx++;
         if (ready !== 1'b1) v_rdy++;
      end
      check("reset_tx_not_high", v_tx, 0);
      check("reset_ready_not_high", v_rdy, 0);

`ifndef EMITTER_UART_FIFO_EN
      // Single byte with exact busy window, then 'A'.
      send_byte(8'h55, 1'b1);
      wait_frames_done("done_55", 4 * FRAME);
      send_byte(8'h41, 1'b1);
      wait_frames_done("done_41", 4 * FRAME);
      check("rx_A", int'(rx_log[rx_log.size()-1]), 8'h41);

      // A byte offered while busy is dropped.
      f0 = frames_seen;
      send_byte(8'h55, 1'b0);
      repeat (100) @(negedge clk);
      data  = 8'hFF;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      wait_frames_done("done_drop", 4 * FRAME);
      lows = 0;
      repeat (2 * FRAME) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("drop_frame_count", frames_seen - f0, 1);
      check("drop_line_idle_lows", lows, 0);
`else
      // FIFO: hold valid for five bytes; depth+1 pushes land on consecutive edges.
      fb[0] = 8'h10; fb[1] = 8'h92; fb[2] = 8'h3E; fb[3] = 8'hC7; fb[4] = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         data  = fb[i];
         valid = 1'b1;
         check("fifo_ready_for_push", int'(ready === 1'b1), 1);
         @(posedge clk);
         exp_q.push_back(fb[i]);
         @(negedge clk);
      end
      valid = 1'b0;
      check("fifo_full_ready_low", int'(ready), 0);
      wait_frames_done("done_fifo", 8 * FRAME);
      check("fifo_queued_gap", last_gap, 1);
`endif

      // Back-to-back with valid held: "Hi", one idle cycle between frames.
      wait_ready("ready_hi", 4 * FRAME);
      data  = 8'h48;
      valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(8'h48);
      @(negedge clk);
      data = 8'h69;
      wait_ready("ready_hi_second", 4 * FRAME);
      @(posedge clk);
      exp_q.push_back(8'h69);
      @(negedge clk);
      valid = 1'b0;
      wait_frames_done("done_hi", 4 * FRAME);
      check("hi_gap", last_gap, 1);
      check("hi_H", int'(rx_log[rx_log.size()-2]), 8'h48);
      check("hi_i", int'(rx_log[rx_log.size()-1]), 8'h69);

      // Asynchronous reset during data bit 3 of 0xC3 (bit 3 is 0).
      send_byte(8'hC3, 1'b0);
      repeat (4 * DIV + DIV / 2 - 1) @(negedge clk);
      check("pre_reset_tx_low", int'(tx), 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_tx_high", int'(tx), 1);
      check("async_reset_ready_high", int'(ready), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ready", int'(ready), 1);
      exp_q.delete();
      send_byte(8'hA5, 1'b0);
      wait_frames_done("done_a5", 4 * FRAME);
      check("rx_A5", int'(rx_log[rx_log.size()-1]), 8'hA5);

      // Randomized bytes and idle gaps.
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 30)) @(negedge clk);
`ifndef EMITTER_UART_FIFO_EN
         send_byte(8'($urandom_range(0, 255)), 1'b1);
`else
         send_byte(8'($urandom_range(0, 255)), 1'b0);
`endif
      end
      wait_frames_done("done_random", 4 * FRAME);

      check("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
